// File: rtl/inst_fetch_unit.sv
// inst_fetch_unit: instruction fetch front end.
// Holds the PC and issues in-order word reads to instruction memory. Returned
// words are buffered in a small FIFO and handed to decode as {inst, inst_pc}
// over a valid/ready handshake. A redirect flushes the wrong-path words.
//
// Build option: define IFU_MISALIGN_CHK_EN to trap misaligned redirect targets.
// The trap sets a sticky misalign_err and parks the unit in HALT until rst.
// Without the macro, the low two bits of redirect_pc are ignored and
// misalign_err stays 0.
module inst_fetch_unit #(
  parameter logic [31:0] PC_RESET   = 32'h0000_0000,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        fetch_en,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  output logic        inst_valid,
  input  logic        inst_ready,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        misalign_err
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam logic [CW:0] DEPTH_W = (CW+1)'(FIFO_DEPTH);

  typedef enum logic {
    S_FETCH = 1'b0,
    S_HALT  = 1'b1
  } state_e;

  state_e        state_q, state_d;
  logic          misalign_q, misalign_d;
  logic [31:0]   pc_q, pc_d;
  logic [31:0]   rsp_pc_q, rsp_pc_d;
  logic [CW-1:0] outstanding_q, outstanding_d;
  logic [CW-1:0] drop_cnt_q, drop_cnt_d;
  logic [CW-1:0] fifo_cnt_q, fifo_cnt_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [63:0]   fifo_mem_q [FIFO_DEPTH];
  logic [63:0]   fifo_mem_d [FIFO_DEPTH];

  logic [CW:0]   credit_used;
  logic          req_fire;
  logic          rsp_take;
  logic          push;
  logic          pop;
  logic          redir_bad;
  logic [31:0]   redir_target;
  logic [63:0]   head;

`ifdef IFU_MISALIGN_CHK_EN
  assign redir_target = redirect_pc;
  assign redir_bad    = redirect_valid && (redirect_pc[1:0] != 2'b00);
`else
  // Misaligned targets are silently rounded down to the containing word.
  logic unused_redir_lo;
  assign unused_redir_lo = ^redirect_pc[1:0];
  assign redir_target    = {redirect_pc[31:2], 2'b00};
  assign redir_bad       = 1'b0;
`endif

  // Credit counts only registered state, so inst_ready never reaches the request path.
  assign credit_used    = {1'b0, outstanding_q} + {1'b0, fifo_cnt_q};
  assign imem_req_valid = !rst && (state_q == S_FETCH) && fetch_en &&
                          !redirect_valid && (credit_used < DEPTH_W);
  assign imem_req_addr  = pc_q;
  assign req_fire       = imem_req_valid && imem_req_ready;

  // A response with nothing outstanding is stray and ignored entirely.
  assign rsp_take   = imem_rsp_valid && (outstanding_q != '0);

  assign inst_valid = (fifo_cnt_q != '0);
  assign pop        = inst_valid && inst_ready;
  assign head       = fifo_mem_q[rd_ptr_q];
  assign inst       = inst_valid ? head[63:32] : 32'h0;
  assign inst_pc    = inst_valid ? head[31:0]  : 32'h0;
  assign misalign_err = misalign_q;

  // Next-state: a redirect overrides everything; HALT keeps the buffer empty.
  always_comb begin
    state_d       = state_q;
    misalign_d    = misalign_q;
    pc_d          = pc_q;
    rsp_pc_d      = rsp_pc_q;
    drop_cnt_d    = drop_cnt_q;
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    fifo_cnt_d    = fifo_cnt_q;
    push          = 1'b0;
    outstanding_d = outstanding_q + CW'(req_fire) - CW'(rsp_take);
    if (redirect_valid) begin
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      fifo_cnt_d = '0;
      pc_d       = redir_target;
      rsp_pc_d   = redir_target;
      // Everything still in flight belongs to the old path; this cycle's
      // response is already discarded, so it is not counted again.
      drop_cnt_d = outstanding_q - CW'(rsp_take);
      if (redir_bad) begin
        state_d    = S_HALT;
        misalign_d = 1'b1;
      end
    end else if (state_q == S_HALT) begin
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      fifo_cnt_d = '0;
      drop_cnt_d = '0;
    end else begin
      if (req_fire) begin
        pc_d = pc_q + 32'd4;
      end
      if (rsp_take) begin
        if (drop_cnt_q != '0) begin
          drop_cnt_d = drop_cnt_q - CW'(1);
        end else begin
          push = 1'b1;
        end
      end
      if (push) begin
        wr_ptr_d = wr_ptr_q + AW'(1);
        rsp_pc_d = rsp_pc_q + 32'd4;
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + AW'(1);
      end
      fifo_cnt_d = fifo_cnt_q + CW'(push) - CW'(pop);
    end
  end

  // Buffer write: store the returned word alongside the PC it was fetched from.
  always_comb begin
    fifo_mem_d = fifo_mem_q;
    if (push) begin
      fifo_mem_d[wr_ptr_q] = {imem_rsp_data, rsp_pc_q};
    end
  end

  // Control state register; only control is reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_FETCH;
      misalign_q    <= 1'b0;
      pc_q          <= PC_RESET;
      rsp_pc_q      <= PC_RESET;
      outstanding_q <= '0;
      drop_cnt_q    <= '0;
      fifo_cnt_q    <= '0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
    end else begin
      state_q       <= state_d;
      misalign_q    <= misalign_d;
      pc_q          <= pc_d;
      rsp_pc_q      <= rsp_pc_d;
      outstanding_q <= outstanding_d;
      drop_cnt_q    <= drop_cnt_d;
      fifo_cnt_q    <= fifo_cnt_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
    end
  end

  // Buffer storage; contents are qualified by fifo_cnt_q, so no reset needed.
  always_ff @(posedge clk) begin
    fifo_mem_q <= fifo_mem_d;
  end

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Testbench for inst_fetch_unit: in-order memory model with random latency,
// and a reference model built on epochs (a redirect starts a new epoch and any
// word from an older epoch is discarded) plus a queue of words awaiting decode.
module tb_inst_fetch_unit;

  logic        clk;
  logic        rst;
  logic        fetch_en;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        inst_valid;
  logic        inst_ready;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        misalign_err;

  // Second instance only checks PC wrap-around from a high reset PC.
  logic        w_req_valid;
  logic [31:0] w_req_addr;
  logic [31:0] w_inst;
  logic [31:0] w_inst_pc;
  logic        w_inst_valid;
  logic        w_misalign_err;

  inst_fetch_unit #(.PC_RESET(32'h0000_0000), .FIFO_DEPTH(4)) u_dut (
    .clk(clk), .rst(rst), .fetch_en(fetch_en),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_req_addr(imem_req_addr), .imem_rsp_valid(imem_rsp_valid),
    .imem_rsp_data(imem_rsp_data), .inst(inst), .inst_pc(inst_pc),
    .inst_valid(inst_valid), .inst_ready(inst_ready),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .misalign_err(misalign_err)
  );

  inst_fetch_unit #(.PC_RESET(32'hFFFF_FFF8), .FIFO_DEPTH(4)) u_wrap (
    .clk(clk), .rst(rst), .fetch_en(1'b1),
    .imem_req_valid(w_req_valid), .imem_req_ready(1'b1),
    .imem_req_addr(w_req_addr), .imem_rsp_valid(1'b0),
    .imem_rsp_data(32'h0), .inst(w_inst), .inst_pc(w_inst_pc),
    .inst_valid(w_inst_valid), .inst_ready(1'b0),
    .redirect_valid(1'b0), .redirect_pc(32'h0),
    .misalign_err(w_misalign_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    int          epoch;
    int          due;
  } req_t;

  req_t        mq[$];   // accepted requests awaiting a response
  logic [31:0] mf[$];   // PCs of words the decoder should see, oldest first
  int          epoch;
  logic        halted;
  logic        exp_mis;
  logic [31:0] exp_req_pc;
  int          cyc;

  int n_tests = 0;
  int n_fail  = 0;
  int first_iv;
  int n_pop;
  logic wrap_chk;

  logic        nx_fetch_en, nx_req_ready, nx_inst_ready, nx_redirect;
  logic [31:0] nx_redirect_pc;
  int          lat_min, lat_max, rsp_pct;
  logic        spur_en;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h5A5A_C3C3;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic reset_dut();
    @(negedge clk);
    rst = 1'b1;
    fetch_en = 1'b1;
    imem_req_ready = 1'b1;
    inst_ready = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc = 32'h0;
    imem_rsp_valid = 1'b0;
    imem_rsp_data = 32'h0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_req_valid", imem_req_valid, 0);
    chk("rst_inst_valid", inst_valid, 0);
    chk("rst_misalign", misalign_err, 0);
    chk("rst_req_addr", imem_req_addr, 32'h0);
    chk("rst_inst", inst, 32'h0);
    chk("rst_inst_pc", inst_pc, 32'h0);
    mq.delete();
    mf.delete();
    epoch = 0;
    halted = 1'b0;
    exp_mis = 1'b0;
    exp_req_pc = 32'h0;
    cyc = 0;
    first_iv = -1;
    n_pop = 0;
  endtask

  task automatic step();
    logic        exp_rv;
    logic        rsp_real;
    logic        do_push;
    logic [31:0] push_pc;
    logic [31:0] wexp;
    req_t        e;
    int          lat;
    @(negedge clk);
    rst = 1'b0;
    fetch_en = nx_fetch_en;
    imem_req_ready = nx_req_ready;
    inst_ready = nx_inst_ready;
    redirect_valid = nx_redirect;
    redirect_pc = nx_redirect_pc;
    rsp_real = (mq.size() != 0) && (mq[0].due <= cyc) &&
               ($urandom_range(99, 0) < rsp_pct);
    if (rsp_real) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data = mem_word(mq[0].addr);
    end else if (mq.size() == 0 && spur_en && $urandom_range(9, 0) == 0) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data = $urandom;
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data = $urandom;
    end
    #1;
    exp_rv = !halted && fetch_en && !redirect_valid && ((mq.size() + mf.size()) < 4);
    chk("req_valid", imem_req_valid, exp_rv);
    if (exp_rv) chk("req_addr", imem_req_addr, exp_req_pc);
    chk("inst_valid", inst_valid, mf.size() != 0);
    if (mf.size() != 0) begin
      chk("inst_pc", inst_pc, mf[0]);
      chk("inst", inst, mem_word(mf[0]));
    end
    chk("misalign_err", misalign_err, exp_mis);
    if (wrap_chk && cyc < 3) begin
      wexp = 32'hFFFF_FFF8 + 32'(cyc * 4);
      chk("wrap_req_valid", w_req_valid, 1);
      chk("wrap_req_addr", w_req_addr, wexp);
    end
    if (inst_valid && first_iv < 0) first_iv = cyc;
    if (inst_valid && inst_ready) n_pop++;

    do_push = 1'b0;
    push_pc = 32'h0;
    if (rsp_real) begin
      e = mq.pop_front();
      if (!redirect_valid && !halted && e.epoch == epoch) begin
        do_push = 1'b1;
        push_pc = e.addr;
      end
    end
    if (exp_rv && imem_req_ready) begin
      lat = $urandom_range(lat_max, lat_min);
      mq.push_back('{exp_req_pc, epoch, cyc + lat});
      exp_req_pc = exp_req_pc + 32'd4;
    end
    if (redirect_valid) begin
      epoch++;
      mf.delete();
`ifdef IFU_MISALIGN_CHK_EN
      if (redirect_pc[1:0] != 2'b00) begin
        halted = 1'b1;
        exp_mis = 1'b1;
      end
`endif
      exp_req_pc = {redirect_pc[31:2], 2'b00};
    end else begin
      if (inst_ready && mf.size() != 0) void'(mf.pop_front());
      if (do_push) mf.push_back(push_pc);
    end
    cyc++;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic nominal();
    nx_fetch_en = 1'b1;
    nx_req_ready = 1'b1;
    nx_inst_ready = 1'b1;
    nx_redirect = 1'b0;
    nx_redirect_pc = 32'h0;
    lat_min = 1;
    lat_max = 1;
    rsp_pct = 100;
    spur_en = 1'b0;
  endtask

  task automatic redirect_to(input logic [31:0] tgt);
    nx_redirect = 1'b1;
    nx_redirect_pc = tgt;
    step();
    nx_redirect = 1'b0;
  endtask

  initial begin
    int guard;
    rst = 1'b1;
    wrap_chk = 1'b1;
    nominal();

    // Streaming from reset with a one-cycle memory, plus PC wrap on u_wrap.
    reset_dut();
    run(20);
    wrap_chk = 1'b0;
    chk("first_inst_cycle", 32'(first_iv), 32'd2);
    chk("throughput_pops", 32'(n_pop), 32'd18);

    // Decode stalls: buffer fills, requests stop, then drain in order.
    reset_dut();
    run(6);
    nx_inst_ready = 1'b0;
    run(10);
    chk("stall_req_valid", imem_req_valid, 0);
    chk("stall_inst_valid", inst_valid, 1);
    nx_inst_ready = 1'b1;
    run(15);

    // Two requests in flight on a slow memory, then redirect to 0x100.
    reset_dut();
    lat_min = 3;
    lat_max = 3;
    guard = 0;
    while (mq.size() < 2 && guard < 20) begin
      step();
      guard++;
    end
    chk("inflight_reached", 32'(mq.size() >= 2), 32'd1);
    redirect_to(32'h0000_0100);
    guard = 0;
    while (!inst_valid && guard < 30) begin
      step();
      guard++;
    end
    chk("redir_first_pc", inst_pc, 32'h0000_0100);
    run(10);

    // Redirect in a cycle that also has a response and a pop.
    nominal();
    reset_dut();
    run(8);
    redirect_to(32'h0000_0200);
    step();
    chk("redir_next_inst_valid", inst_valid, 0);
    chk("redir_next_req_valid", imem_req_valid, 1);
    chk("redir_next_req_addr", imem_req_addr, 32'h0000_0200);
    run(10);

    // Randomized traffic.
    reset_dut();
    lat_min = 1;
    lat_max = 4;
    rsp_pct = 80;
    spur_en = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      logic [31:0] tgt;
      nx_fetch_en = ($urandom_range(9, 0) != 0);
      nx_req_ready = ($urandom_range(9, 0) < 7);
      nx_inst_ready = ($urandom_range(9, 0) < 7);
      nx_redirect = ($urandom_range(99, 0) < 3);
      tgt = $urandom & 32'h0000_0FFF;
      if ($urandom_range(9, 0) == 0) tgt = 32'hFFFF_FFF0;
`ifdef IFU_MISALIGN_CHK_EN
      tgt[1:0] = 2'b00;
`endif
      nx_redirect_pc = tgt;
      step();
    end

    // Misaligned redirect target.
    nominal();
    reset_dut();
    run(5);
    redirect_to(32'h0000_0102);
    step();
`ifdef IFU_MISALIGN_CHK_EN
    chk("misalign_set", misalign_err, 1);
    chk("misalign_no_req", imem_req_valid, 0);
`else
    chk("aligned_req_valid", imem_req_valid, 1);
    chk("aligned_req_addr", imem_req_addr, 32'h0000_0100);
`endif
    run(10);

    reset_dut();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
